// File: rtl/delay_meter_pkg.sv
// Shared definitions for the delay meter: FSM encoding and default widths
// common with the channel delay generators.
package delay_meter_pkg;

  localparam int CNT_W_DEF = 36;
  localparam int NUM_W_DEF = 16;

  // IDLE and COUNT are held in the state register. DONE is never stored in
  // the register. It is reported on the debug view during the cycle that
  // valid is high, which is also the cycle the register has returned to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_meter_rise_det.sv
// One-register rising-edge detector. The history register clears on reset,
// so an input that is already high when reset releases is seen as a rise.
module rise_det (
  input  logic clk_Meter,
  input  logic rst_Meter,
  input  logic sig_in,
  output logic rise
);

  logic prev_q;

  // Remember the previous cycle's level.
  always_ff @(posedge clk_Meter) begin
    if (rst_Meter) prev_q <= 1'b0;
    else           prev_q <= sig_in;
  end

  assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/delay_meter.sv
// Measures clk_Meter cycles from a start_in rise to the next stop_in rise.
// It publishes each result and keeps running min/max/count statistics.
// valid and abort are one-cycle pulses with no ready/back-pressure. A
// consumer must capture delay_val/overflow in the cycle valid is high.
// delay_val stays stable until the next valid.
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk_Meter,
  input  logic             rst_Meter,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             clr_stats,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] delay_val,
  output logic             overflow,
  output logic             abort,
  output logic [CNT_W-1:0] delay_min,
  output logic [CNT_W-1:0] delay_max,
  output logic [NUM_W-1:0] meas_num,
  output state_t           fsm_state
);

  logic             start_rise;
  logic             stop_rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;
  logic             abort_d;
  logic [CNT_W-1:0] res_val;
  logic             res_ovf;

  rise_det u_start_det (
    .clk_Meter (clk_Meter),
    .rst_Meter (rst_Meter),
    .sig_in    (start_in),
    .rise      (start_rise)
  );

  rise_det u_stop_det (
    .clk_Meter (clk_Meter),
    .rst_Meter (rst_Meter),
    .sig_in    (stop_in),
    .rise      (stop_rise)
  );

  // FSM state register and interval counter.
  always_ff @(posedge clk_Meter) begin
    if (rst_Meter) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and result decision.
  // In the COUNT state, cnt_q equals the current cycle minus the start cycle.
  // Precedence in COUNT is: a stop rise, then a start fall (abort), then
  // counter saturation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    abort_d = 1'b0;
    res_val = '0;
    res_ovf = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          if (stop_rise) begin
            done    = 1'b1;
            res_val = '0;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      COUNT: begin
        if (stop_rise) begin
          done    = 1'b1;
          res_val = cnt_q;
          state_d = IDLE;
        end else if (!start_in) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '1) begin
          done    = 1'b1;
          res_val = '1;
          res_ovf = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers and event pulses.
  always_ff @(posedge clk_Meter) begin
    if (rst_Meter) begin
      valid     <= 1'b0;
      abort     <= 1'b0;
      delay_val <= '0;
      overflow  <= 1'b0;
    end else begin
      valid <= done;
      abort <= abort_d;
      if (done) begin
        delay_val <= res_val;
        overflow  <= res_ovf;
      end
    end
  end

  // Statistics. A clear takes priority over a result completing in the same cycle.
  always_ff @(posedge clk_Meter) begin
    if (rst_Meter || clr_stats) begin
      delay_min <= '1;
      delay_max <= '0;
      meas_num  <= '0;
    end else if (done) begin
      if (!res_ovf) begin
        if (res_val < delay_min) delay_min <= res_val;
        if (res_val > delay_max) delay_max <= res_val;
      end
      if (meas_num != '1) meas_num <= meas_num + NUM_W'(1);
    end
  end

  assign busy      = (state_q == COUNT);
  assign fsm_state = valid ? DONE : state_q;

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter (CNT_W=8 so saturation is reachable).
module tb_delay_meter;
  import delay_meter_pkg::*;

  localparam int W  = 8;
  localparam int NW = 16;
  localparam int EW = 73;  // {cyc[31:0], num[15:0], max[7:0], min[7:0], ovf, val[7:0]}

  logic          clk_Meter = 1'b0;
  logic          rst_Meter;
  logic          start_in;
  logic          stop_in;
  logic          clr_stats;
  logic          busy;
  logic          valid;
  logic [W-1:0]  delay_val;
  logic          overflow;
  logic          abort;
  logic [W-1:0]  delay_min;
  logic [W-1:0]  delay_max;
  logic [NW-1:0] meas_num;
  state_t        fsm_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   abort_q[$];

  delay_meter #(.CNT_W(W), .NUM_W(NW)) dut (
    .clk_Meter (clk_Meter),
    .rst_Meter (rst_Meter),
    .start_in  (start_in),
    .stop_in   (stop_in),
    .clr_stats (clr_stats),
    .busy      (busy),
    .valid     (valid),
    .delay_val (delay_val),
    .overflow  (overflow),
    .abort     (abort),
    .delay_min (delay_min),
    .delay_max (delay_max),
    .meas_num  (meas_num),
    .fsm_state (fsm_state)
  );

  // Clock and cycle counter; cycle N starts at the Nth rising edge.
  always #5 clk_Meter = ~clk_Meter;
  always @(posedge clk_Meter) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_Meter);
    #1;
  endtask

  task automatic push_exp(input int c, input int num, input int mx, input int mn,
                          input logic ovf, input int val);
    exp_q.push_back({32'(c), 16'(num), 8'(mx), 8'(mn), ovf, 8'(val)});
  endtask

  // Drives one start/stop measurement of d cycles and checks busy on each cycle.
  task automatic measure(input int d, input int emin, input int emax, input int enum_);
    int s;
    s = cyc;
    start_in = 1'b1;
    check("busy_at_start", 64'(busy), 64'd0);
    if (d != 0) begin
      for (int i = 1; i <= d; i++) begin
        step(1);
        check("busy_counting", 64'(busy), 64'd1);
      end
    end
    stop_in = 1'b1;
    push_exp(s + d + 1, enum_, emax, emin, 1'b0, d);
    step(1);
    check("busy_after_stop", 64'(busy), 64'd0);
    start_in = 1'b0;
    stop_in  = 1'b0;
    step(5);
  endtask

  task automatic check_stats(input string tag, input int mn, input int mx, input int num);
    check({tag, "_min"}, 64'(delay_min), 64'(mn));
    check({tag, "_max"}, 64'(delay_max), 64'(mx));
    check({tag, "_num"}, 64'(meas_num), 64'(num));
  endtask

  // Scoreboard monitor: compares each valid/abort pulse with the expected queues.
  always @(negedge clk_Meter) begin
    logic [EW-1:0] e;
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("valid_cycle", 64'(cyc),       64'(e[72:41]));
        check("delay_val",   64'(delay_val), 64'(e[7:0]));
        check("overflow",    64'(overflow),  64'(e[8]));
        check("delay_min",   64'(delay_min), 64'(e[16:9]));
        check("delay_max",   64'(delay_max), 64'(e[24:17]));
        check("meas_num",    64'(meas_num),  64'(e[40:25]));
      end
    end
    if (abort) begin
      if (abort_q.size() == 0) check("unexpected_abort", 64'd1, 64'd0);
      else check("abort_cycle", 64'(cyc), 64'(abort_q.pop_front()));
    end
  end

  // Stimulus.
  initial begin
    int s;
    rst_Meter = 1'b1;
    start_in  = 1'b0;
    stop_in   = 1'b0;
    clr_stats = 1'b0;
    step(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_val", 64'(delay_val), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check_stats("rst", 255, 0, 0);
    rst_Meter = 1'b0;
    step(5);

    // Single 100-cycle measurement.
    measure(100, 100, 100, 1);
    // Start and stop rising together give 0 with no busy cycle.
    measure(0, 0, 100, 2);

    // No stop: saturates at 255 with overflow, valid 256 cycles after start.
    s = cyc;
    start_in = 1'b1;
    push_exp(s + 256, 3, 100, 0, 1'b1, 255);
    step(300);
    check("no_retrigger_busy", 64'(busy), 64'd0);
    start_in = 1'b0;
    step(5);

    // Stop rising in the last counting cycle: 255 without overflow.
    measure(255, 0, 255, 4);

    // Abort: start falls 20 cycles after its rise; a later stop rise in IDLE does nothing.
    s = cyc;
    start_in = 1'b1;
    step(20);
    start_in = 1'b0;
    abort_q.push_back(32'(s + 21));
    step(1);
    check("abort_busy", 64'(busy), 64'd0);
    step(5);
    stop_in = 1'b1;
    step(1);
    stop_in = 1'b0;
    step(5);
    check("abort_val_kept", 64'(delay_val), 64'd255);
    check("abort_ovf_kept", 64'(overflow), 64'd0);
    check_stats("abort", 0, 255, 4);

    // Statistics over 50, 30, 70 and a clear afterwards.
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    check_stats("clr1", 255, 0, 0);
    measure(50, 50, 50, 1);
    measure(30, 30, 50, 2);
    measure(70, 30, 70, 3);
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    check_stats("clr2", 255, 0, 0);
    check("clr2_val", 64'(delay_val), 64'd70);

    // Clear in the stop cycle: result still published, stats stay cleared.
    s = cyc;
    start_in = 1'b1;
    step(10);
    stop_in   = 1'b1;
    clr_stats = 1'b1;
    push_exp(s + 11, 0, 0, 255, 1'b0, 10);
    step(1);
    start_in  = 1'b0;
    stop_in   = 1'b0;
    clr_stats = 1'b0;
    step(5);

    // Reset in the middle of a measurement, then a fresh 40-cycle measurement.
    start_in = 1'b1;
    step(10);
    rst_Meter = 1'b1;
    start_in  = 1'b0;
    step(1);
    rst_Meter = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_abort", 64'(abort), 64'd0);
    check("midrst_val", 64'(delay_val), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    check_stats("midrst", 255, 0, 0);
    step(3);
    measure(40, 40, 40, 1);

    // Wait for the scoreboard to drain, with a bound.
    for (int i = 0; i < 50 && (exp_q.size() != 0 || abort_q.size() != 0); i++) step(1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("abort_q_drained", 64'(abort_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog in case the stimulus is stuck.
  initial begin
    #100000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
